reg_file_32x32: RTL and testbench

Register file for the single-cycle/pipelined 32-bit datapath: 32 registers of 32 bits, two combinational read ports and one synchronous write port. Read port B feeds the ALU-source 32-bit 2:1 select stage, which chooses between register operand and immediate. Read port A feeds the ALU directly. Register 0 is hardwired to zero.

---
 rtl/reg_file_32x32_pkg.sv | 15 +
 rtl/reg_file_32x32_decoder_5to32.sv | 18 +
 rtl/reg_file_32x32.sv | 54 +++++
 tb/tb_reg_file_32x32.sv | 126 ++++++++++++
 4 files changed

// File: rtl/reg_file_32x32_pkg.sv
// Shared datapath constants for the 32x32 register file, ALU-source mux and ALU.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_32x32_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/reg_file_32x32_decoder_5to32.sv
// One-hot write-enable decoder: gated by write enable and reset; r0 is never enabled.
module decoder_5to32
  import reg_file_32x32_pkg::*;
(
  input  logic                i_wr_en,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_wr_en && !i_reset)
      o_we[i_addr] = 1'b1;
    o_we[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 = 0.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_32x32
  import reg_file_32x32_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             w_we;
  logic [DATA_W-1:0]               w_rd_a;
  logic [DATA_W-1:0]               w_rd_b;

  decoder_5to32 u_dec (
    .i_wr_en (i_wr_en),
    .i_reset (i_reset),
    .i_addr  (i_wr_addr),
    .o_we    (w_we)
  );

  // r0 is cleared by reset but never enabled; reads of address 0 are forced to zero anyway.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_reset)
        r_regs[i] <= '0;
      else if (w_we[i])
        r_regs[i] <= i_wr_data;
    end
  end

  always_comb begin
    w_rd_a = (i_rd_addr_a == ZERO_REG) ? '0 : r_regs[i_rd_addr_a];
    w_rd_b = (i_rd_addr_b == ZERO_REG) ? '0 : r_regs[i_rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so the WB/ID hazard resolves without a stall.
    if (i_wr_en && !i_reset && i_wr_addr != ZERO_REG) begin
      if (i_rd_addr_a == i_wr_addr) w_rd_a = i_wr_data;
      if (i_rd_addr_b == i_wr_addr) w_rd_b = i_wr_data;
    end
`endif
  end

  assign o_rd_data_a = w_rd_a;
  assign o_rd_data_b = w_rd_b;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed table-driven bench for reg_file_32x32; follows REG_FILE_BYPASS_EN if defined.
module tb_reg_file_32x32;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data_a, rd_data_b;

  int n_vec = 0;
  int n_err = 0;

  reg_file_32x32 dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] ra, logic [4:0] rb, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] ra, logic [4:0] rb);
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Expected values are what the ports show during the cycle, before that cycle's edge.
    vecs.push_back(mk(0, 1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd7,  32'h00000011, 5'd7,  5'd7,  BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0));
    vecs.push_back(mk(0, 1, 5'd7,  32'h00000022, 5'd7,  5'd7,  BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22, 32'h22));
    vecs.push_back(mk(0, 1, 5'd9,  32'hAAAA0001, 5'd9,  5'd9,  BYP ? 32'hAAAA0001 : 32'h0, BYP ? 32'hAAAA0001 : 32'h0));
    vecs.push_back(mk(1, 1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd7,  32'hAAAA0001, 32'h22));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd9,  5'd7,  32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd3,  32'hA5A5A5A5, 5'd4,  5'd3,  32'h0, BYP ? 32'hA5A5A5A5 : 32'h0));
    vecs.push_back(mk(0, 1, 5'd4,  32'h5A5A5A5A, 5'd4,  5'd3,  BYP ? 32'h5A5A5A5A : 32'h0, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd4,  5'd3,  32'h5A5A5A5A, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 1, 5'd31, 32'h80000001, 5'd31, 5'd30, BYP ? 32'h80000001 : 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h80000001, 32'h80000001));
    vecs.push_back(mk(0, 0, 5'd31, 32'h0000FFFF, 5'd31, 5'd4,  32'h80000001, 32'h5A5A5A5A));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd31, 5'd3,  32'h80000001, 32'hA5A5A5A5));

    // Fill r1..r31 with all-ones, then a single reset cycle must clear everything.
    for (int a = 1; a < 32; a++)
      drive(0, 1, 5'(a), 32'hFFFFFFFF, 5'd0, 5'd0);
    drive(1, 1, 5'd17, 32'h0, 5'd17, 5'd31);
    chk("fill_a", 17, rd_data_a, 32'hFFFFFFFF);
    chk("fill_b", 31, rd_data_b, 32'hFFFFFFFF);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      chk("rst_a", a, rd_data_a, 32'h0);
      chk("rst_b", 31 - a, rd_data_b, 32'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      chk("vec_a", i, rd_data_a, vecs[i].ea);
      chk("vec_b", i, rd_data_b, vecs[i].eb);
    end

    // Multi-cycle reset with writes held: all dropped, first non-reset edge writes.
    drive(1, 1, 5'd2, 32'h11112222, 5'd2, 5'd2);
    drive(1, 1, 5'd2, 32'h33334444, 5'd2, 5'd4);
    chk("mrst_a", 0, rd_data_a, 32'h0);
    chk("mrst_b", 0, rd_data_b, 32'h0);
    drive(0, 1, 5'd2, 32'h13579BDF, 5'd2, 5'd31);
    chk("resume_a", 0, rd_data_a, BYP ? 32'h13579BDF : 32'h0);
    chk("resume_b", 0, rd_data_b, 32'h0);
    drive(0, 0, 5'd0, 32'h0, 5'd2, 5'd2);
    chk("resume_a", 1, rd_data_a, 32'h13579BDF);
    chk("resume_b", 1, rd_data_b, 32'h13579BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
